// File: rtl/uart_regs_pkg.sv
// Shared UART register map, arbiter state encoding and init-write payload.
package uart_regs_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned STEP_W = 3;
  localparam int unsigned INIT_STEPS = 6;

  localparam logic [ADDR_W-1:0] RBR_THR = 3'd0;
  localparam logic [ADDR_W-1:0] IER     = 3'd1;
  localparam logic [ADDR_W-1:0] IIR_FCR = 3'd2;
  localparam logic [ADDR_W-1:0] LCR     = 3'd3;
  localparam logic [ADDR_W-1:0] LSR     = 3'd5;

  localparam logic [DATA_W-1:0] LCR_DLAB = 8'h83;

  typedef enum logic [2:0] {
    ST_WAIT_EN = 3'd0,
    ST_INIT    = 3'd1,
    ST_IDLE    = 3'd2,
    ST_ACCESS  = 3'd3,
    ST_CAPTURE = 3'd4
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } init_wr_t;

endpackage

// File: rtl/uart_bus_arbiter_if.sv
// 16550-style register bus between the arbiter (master) and the UART core (slave).
interface uart_bus_arbiter_if;
  import uart_regs_pkg::*;

  logic [ADDR_W-1:0] uart_addr_o;
  logic [DATA_W-1:0] uart_wdata_o;
  logic              uart_we_o;
  logic              uart_re_o;
  logic [DATA_W-1:0] uart_rdata_i;

  modport master (output uart_addr_o, output uart_wdata_o, output uart_we_o,
                  output uart_re_o, input uart_rdata_i);
  modport slave  (input uart_addr_o, input uart_wdata_o, input uart_we_o,
                  input uart_re_o, output uart_rdata_i);
endinterface

// File: rtl/uart_init_rom.sv
// Combinational table of the UART configuration writes, indexed by init step.
module uart_init_rom
  import uart_regs_pkg::*;
#(
  parameter logic [15:0]       DIVISOR = 16'h000E,
  parameter logic [DATA_W-1:0] LCR_VAL = 8'h03,
  parameter logic [DATA_W-1:0] FCR_VAL = 8'h01,
  parameter logic [DATA_W-1:0] IER_VAL = 8'h01
) (
  input  logic [STEP_W-1:0] step,
  output init_wr_t          wr_c
);

  // Steps 1/2 hit the divisor latches because DLAB is set by step 0.
  always_comb begin
    wr_c = '0;
    case (step)
      3'd0:    wr_c = '{addr: LCR,     data: LCR_DLAB};
      3'd1:    wr_c = '{addr: IER,     data: DIVISOR[15:8]};
      3'd2:    wr_c = '{addr: RBR_THR, data: DIVISOR[7:0]};
      3'd3:    wr_c = '{addr: LCR,     data: LCR_VAL};
      3'd4:    wr_c = '{addr: IIR_FCR, data: FCR_VAL};
      3'd5:    wr_c = '{addr: IER,     data: IER_VAL};
      default: wr_c = '0;
    endcase
  end

endmodule

// File: rtl/uart_bus_arbiter.sv
// UART register-bus owner: runs the init sequence, then round-robins two requesters.
module uart_bus_arbiter
  import uart_regs_pkg::*;
#(
  parameter logic [15:0]       DIVISOR = 16'h000E,
  parameter logic [DATA_W-1:0] LCR_VAL = 8'h03,
  parameter logic [DATA_W-1:0] FCR_VAL = 8'h01,
  parameter logic [DATA_W-1:0] IER_VAL = 8'h01
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              Enable,
  output logic              init_done,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              wr0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              wr1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  uart_bus_arbiter_if.master bus
);

  state_t            state;
  logic [STEP_W-1:0] init_step;
  logic              last_grant;
  logic              grant;
  logic              lat_wr;
  init_wr_t          rom_c;

  uart_init_rom #(
    .DIVISOR (DIVISOR),
    .LCR_VAL (LCR_VAL),
    .FCR_VAL (FCR_VAL),
    .IER_VAL (IER_VAL)
  ) u_init_rom (
    .step (init_step),
    .wr_c (rom_c)
  );

  // Outputs are registered on the transition into the state that owns them,
  // so strobes are visible during ST_INIT/ST_ACCESS and ack the cycle after ST_CAPTURE.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state            <= ST_WAIT_EN;
      init_step        <= '0;
      last_grant       <= 1'b1;
      grant            <= 1'b0;
      lat_wr           <= 1'b0;
      init_done        <= 1'b0;
      ack0             <= 1'b0;
      ack1             <= 1'b0;
      rdata0           <= '0;
      rdata1           <= '0;
      bus.uart_addr_o  <= '0;
      bus.uart_wdata_o <= '0;
      bus.uart_we_o    <= 1'b0;
      bus.uart_re_o    <= 1'b0;
    end else begin
      ack0          <= 1'b0;
      ack1          <= 1'b0;
      bus.uart_we_o <= 1'b0;
      bus.uart_re_o <= 1'b0;
      case (state)
        ST_WAIT_EN: begin
          if (Enable) begin
            state            <= ST_INIT;
            bus.uart_we_o    <= 1'b1;
            bus.uart_addr_o  <= rom_c.addr;
            bus.uart_wdata_o <= rom_c.data;
            init_step        <= init_step + 3'd1;
          end
        end
        ST_INIT: begin
          if (init_step == STEP_W'(INIT_STEPS)) begin
            state     <= ST_IDLE;
            init_step <= '0;
            init_done <= 1'b1;
          end else begin
            bus.uart_we_o    <= 1'b1;
            bus.uart_addr_o  <= rom_c.addr;
            bus.uart_wdata_o <= rom_c.data;
            init_step        <= init_step + 3'd1;
          end
        end
        ST_IDLE: begin
          if (req0 && (!req1 || last_grant)) begin
            state            <= ST_ACCESS;
            grant            <= 1'b0;
            last_grant       <= 1'b0;
            lat_wr           <= wr0;
            bus.uart_addr_o  <= addr0;
            bus.uart_wdata_o <= wdata0;
            bus.uart_we_o    <= wr0;
            bus.uart_re_o    <= !wr0;
          end else if (req1) begin
            state            <= ST_ACCESS;
            grant            <= 1'b1;
            last_grant       <= 1'b1;
            lat_wr           <= wr1;
            bus.uart_addr_o  <= addr1;
            bus.uart_wdata_o <= wdata1;
            bus.uart_we_o    <= wr1;
            bus.uart_re_o    <= !wr1;
          end
        end
        ST_ACCESS: state <= ST_CAPTURE;
        ST_CAPTURE: begin
          state <= ST_IDLE;
          if (grant) begin
            ack1 <= 1'b1;
            if (!lat_wr) rdata1 <= bus.uart_rdata_i;
          end else begin
            ack0 <= 1'b1;
            if (!lat_wr) rdata0 <= bus.uart_rdata_i;
          end
        end
        default: state <= ST_WAIT_EN;
      endcase
    end
  end

endmodule
